// File: rtl/ami_w.sv
// ----------------------------------------------------------------------------
// ami_w : AXI4 master write engine
//
// Takes one burst command at a time from a user write client, presents it on
// the AXI AW channel, streams the user's beats onto W (tagging the final beat
// with WLAST), and hands B responses straight back to the user. Up to MAX_OUT
// bursts may have their AW accepted while still waiting for B.
//
// The block does not split bursts. A command that crosses a 4KB boundary is
// still issued unchanged, and err_4kb is pulsed for one cycle.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   cmd_id/addr/len/size/burst  burst command fields
//   cmd_valid / cmd_ready       command handshake
//   usr_wdata/usr_wstrb         user beat data and strobes
//   usr_wvalid / usr_wready     user beat handshake
//   usr_bid/usr_bresp/usr_bvalid  B response forwarded to the user
//   usr_bready                  user B ready (drives BREADY)
//   AWID..AWBURST, AWVALID      registered AXI AW channel; AWREADY is an input
//   WDATA/WSTRB/WLAST/WVALID    AXI W channel; WREADY is an input
//   BID/BRESP/BVALID, BREADY    AXI B channel
//   outstanding                 bursts with AW accepted and B not yet accepted
//   err_4kb                     1-cycle pulse: accepted INCR cmd crosses 4KB
//   err_bresp                   sticky: a B handshake carried BRESP != OKAY
//   err_bunexp                  sticky: BVALID seen with nothing outstanding
// ----------------------------------------------------------------------------
module ami_w #(
   parameter int AXI_DW     = 128,
   parameter int AXI_AW     = 40,
   parameter int AXI_IW     = 8,
   parameter int AXI_LW     = 8,
   parameter int AXI_SW     = 3,
   parameter int AXI_BURSTW = 2,
   parameter int AXI_BRESPW = 2,
   parameter int MAX_OUT    = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,

   input  logic [AXI_IW-1:0]             cmd_id,
   input  logic [AXI_AW-1:0]             cmd_addr,
   input  logic [AXI_LW-1:0]             cmd_len,
   input  logic [AXI_SW-1:0]             cmd_size,
   input  logic [AXI_BURSTW-1:0]         cmd_burst,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,

   input  logic [AXI_DW-1:0]             usr_wdata,
   input  logic [AXI_DW/8-1:0]           usr_wstrb,
   input  logic                          usr_wvalid,
   output logic                          usr_wready,

   output logic [AXI_IW-1:0]             usr_bid,
   output logic [AXI_BRESPW-1:0]         usr_bresp,
   output logic                          usr_bvalid,
   input  logic                          usr_bready,

   output logic [AXI_IW-1:0]             AWID,
   output logic [AXI_AW-1:0]             AWADDR,
   output logic [AXI_LW-1:0]             AWLEN,
   output logic [AXI_SW-1:0]             AWSIZE,
   output logic [AXI_BURSTW-1:0]         AWBURST,
   output logic                          AWVALID,
   input  logic                          AWREADY,

   output logic [AXI_DW-1:0]             WDATA,
   output logic [AXI_DW/8-1:0]           WSTRB,
   output logic                          WLAST,
   output logic                          WVALID,
   input  logic                          WREADY,

   input  logic [AXI_IW-1:0]             BID,
   input  logic [AXI_BRESPW-1:0]         BRESP,
   input  logic                          BVALID,
   output logic                          BREADY,

   output logic [$clog2(MAX_OUT+1)-1:0]  outstanding,
   output logic                          err_4kb,
   output logic                          err_bresp,
   output logic                          err_bunexp
);

   localparam int OCW = $clog2(MAX_OUT + 1);
   localparam logic [OCW:0]            MAX_OUT_V  = (OCW + 1)'(MAX_OUT);
   localparam logic [AXI_BURSTW-1:0]   BURST_INCR = AXI_BURSTW'(1);

   typedef enum logic {
      ST_IDLE,
      ST_BURST
   } state_t;

   state_t            st;
   logic [AXI_LW-1:0] beat_cnt;
   logic              aw_done;
   logic              w_done;

   logic              aw_hs;
   logic              w_hs;
   logic              b_hs;
   logic              cmd_hs;
   logic              w_open;
   logic [OCW:0]      out_after_aw;
   logic [13:0]       burst_bytes;
   logic [13:0]       burst_end;
   logic              crosses_4kb;

   // Handshake decode, W-channel gating and B pass-through.
   // The W channel is open only while a burst is active and its last beat has
   // not yet been sent. This lets the beats run ahead of AW acceptance.
   always_comb begin
      aw_hs      = AWVALID && AWREADY;
      w_open     = (st == ST_BURST) && !w_done;
      WVALID     = w_open && usr_wvalid;
      usr_wready = w_open && WREADY;
      WDATA      = usr_wdata;
      WSTRB      = usr_wstrb;
      WLAST      = (beat_cnt == AWLEN);
      w_hs       = WVALID && WREADY;

      BREADY     = usr_bready;
      usr_bid    = BID;
      usr_bresp  = BRESP;
      usr_bvalid = BVALID;
      b_hs       = BVALID && usr_bready;

      // A burst whose AW handshakes in this cycle already counts against the cap.
      out_after_aw = {1'b0, outstanding} + (OCW + 1)'(aw_hs);
      cmd_ready    = (st == ST_IDLE) && (out_after_aw < MAX_OUT_V);
      cmd_hs       = cmd_valid && cmd_ready;

      // 14 bits holds the worst case: a 4095 offset plus 256 beats of 16 bytes.
      burst_bytes = (14'(cmd_len) + 14'd1) << cmd_size;
      burst_end   = 14'(cmd_addr[11:0]) + burst_bytes;
      crosses_4kb = (cmd_burst == BURST_INCR) && (burst_end > 14'd4096);
   end

   // Burst sequencer. AW and W are tracked independently. The burst retires
   // in the cycle where both are complete, and handshakes that complete in
   // that same cycle also count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st       <= ST_IDLE;
         AWID     <= '0;
         AWADDR   <= '0;
         AWLEN    <= '0;
         AWSIZE   <= '0;
         AWBURST  <= '0;
         AWVALID  <= 1'b0;
         beat_cnt <= '0;
         aw_done  <= 1'b0;
         w_done   <= 1'b0;
      end else begin
         case (st)
            ST_IDLE: begin
               if (cmd_hs) begin
                  AWID     <= cmd_id;
                  AWADDR   <= cmd_addr;
                  AWLEN    <= cmd_len;
                  AWSIZE   <= cmd_size;
                  AWBURST  <= cmd_burst;
                  AWVALID  <= 1'b1;
                  beat_cnt <= '0;
                  aw_done  <= 1'b0;
                  w_done   <= 1'b0;
                  st       <= ST_BURST;
               end
            end
            ST_BURST: begin
               if (aw_hs) begin
                  AWVALID <= 1'b0;
                  aw_done <= 1'b1;
               end
               if (w_hs) begin
                  beat_cnt <= beat_cnt + AXI_LW'(1);
                  if (WLAST) begin
                     w_done <= 1'b1;
                  end
               end
               if ((aw_done || aw_hs) && (w_done || (w_hs && WLAST))) begin
                  st <= ST_IDLE;
               end
            end
            default: st <= ST_IDLE;
         endcase
      end
   end

   // Outstanding-burst counter and error flags. An unexpected B response is
   // still forwarded, but it must not drive the counter below zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outstanding <= '0;
         err_4kb     <= 1'b0;
         err_bresp   <= 1'b0;
         err_bunexp  <= 1'b0;
      end else begin
         if (aw_hs && !b_hs) begin
            outstanding <= outstanding + OCW'(1);
         end else if (b_hs && !aw_hs && (outstanding != '0)) begin
            outstanding <= outstanding - OCW'(1);
         end
         err_4kb <= cmd_hs && crosses_4kb;
         if (b_hs && (BRESP != '0)) begin
            err_bresp <= 1'b1;
         end
         if (BVALID && (outstanding == '0)) begin
            err_bunexp <= 1'b1;
         end
      end
   end

endmodule
